// File: rtl/timebase_v2.sv
// Free-running timebase with a split lo/hi counter (registered carry), tap strobes
// on selected ticks bits, a wrap strobe, and a one-shot compare alarm.
module timebase_v2 #(
    parameter int WIDTH    = 27,
    parameter int LO_WIDTH = 12,
    parameter int NTAPS    = 6,
    parameter int TAP_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             cmp_arm,
    input  logic [WIDTH-1:0] cmp_val,
    output logic [WIDTH-1:0] ticks,
    output logic [NTAPS-1:0] taps,
    output logic             wrap,
    output logic             alarm
);
    localparam int HI_W = WIDTH - LO_WIDTH;

    logic [LO_WIDTH-1:0] lo_q, lo_dly_q;
    logic [HI_W-1:0]     hi_q;
    logic                carry_q;
    logic [WIDTH-1:0]    ticks_q, ticks_d;
    logic [NTAPS-1:0]    prev_q, edge_q, taps_q, tap_bit, edge_d;
    logic                wrap_q, wrap_d;
    logic                armed_q, alarm_q;
    logic [WIDTH-1:0]    cmp_q;

    // lo is delayed one stage so it lines up with hi after the registered carry
    assign ticks_d = {hi_q, lo_dly_q};
    assign wrap_d  = (&ticks_q) && (ticks_d == '0);

    for (genvar k = 0; k < NTAPS; k++) begin : g_tap
        localparam int TBIT = (k * (WIDTH - 1)) / (NTAPS - 1);
        assign tap_bit[k] = ticks_q[TBIT];
    end

    assign edge_d = (TAP_MODE != 0) ? (tap_bit & ~prev_q) : (tap_bit ^ prev_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_q     <= '0;
            lo_dly_q <= '0;
            carry_q  <= 1'b0;
            hi_q     <= '0;
            ticks_q  <= '0;
            prev_q   <= '0;
            edge_q   <= '0;
            taps_q   <= '0;
            wrap_q   <= 1'b0;
        end else if (clr) begin
            lo_q     <= '0;
            lo_dly_q <= '0;
            carry_q  <= 1'b0;
            hi_q     <= '0;
            ticks_q  <= '0;
            prev_q   <= '0;
            edge_q   <= '0;
            taps_q   <= '0;
            wrap_q   <= 1'b0;
        end else begin
            if (en) lo_q <= lo_q + 1'b1;
            carry_q  <= en && (&lo_q);
            hi_q     <= hi_q + HI_W'(carry_q);
            lo_dly_q <= lo_q;
            ticks_q  <= ticks_d;
            prev_q   <= tap_bit;
            edge_q   <= edge_d;
            taps_q   <= edge_q;
            wrap_q   <= wrap_d;
        end
    end

    // Alarm path ignores clr; an arm strobe wins over a match on the old value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_q <= 1'b0;
            cmp_q   <= '0;
            alarm_q <= 1'b0;
        end else if (cmp_arm) begin
            armed_q <= 1'b1;
            cmp_q   <= cmp_val;
            alarm_q <= 1'b0;
        end else if (armed_q && (ticks_q == cmp_q)) begin
            armed_q <= 1'b0;
            alarm_q <= 1'b1;
        end else begin
            alarm_q <= 1'b0;
        end
    end

    assign ticks = ticks_q;
    assign taps  = taps_q;
    assign wrap  = wrap_q;
    assign alarm = alarm_q;
endmodule

// File: tb/tb_timebase_v2.sv
// Scoreboard bench: the driver pushes the expected outputs for every edge, a
// separate monitor pops and compares; two instances cover both tap modes.
module tb_timebase_v2;
    logic       clk, rst, en, clr, cmp_arm;
    logic [7:0] cmp_val;
    logic [7:0] ticks0, ticks1;
    logic [2:0] taps0, taps1;
    logic       wrap0, wrap1, alarm0, alarm1;

    timebase_v2 #(.WIDTH(8), .LO_WIDTH(3), .NTAPS(3), .TAP_MODE(0)) u_m0 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .cmp_arm(cmp_arm), .cmp_val(cmp_val),
        .ticks(ticks0), .taps(taps0), .wrap(wrap0), .alarm(alarm0));
    timebase_v2 #(.WIDTH(8), .LO_WIDTH(3), .NTAPS(3), .TAP_MODE(1)) u_m1 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .cmp_arm(cmp_arm), .cmp_val(cmp_val),
        .ticks(ticks1), .taps(taps1), .wrap(wrap1), .alarm(alarm1));

    typedef struct {
        logic [7:0] t;
        logic [2:0] tp0, tp1;
        logic       w, a;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   done = 0;
    event async_chk;

    // reference state: ideal count, 2-deep latency line, ticks history, alarm
    logic [7:0] ideal, h1, h2, old;
    logic [7:0] tk [4];
    logic       armed_m, al_m;
    logic [7:0] cmpv_m;

    localparam int TAPB [3] = '{0, 3, 7};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_zero();
        ideal = '0; h1 = '0; h2 = '0;
        for (int i = 0; i < 4; i++) tk[i] = '0;
        armed_m = 1'b0; al_m = 1'b0; cmpv_m = '0;
    endtask

    task automatic push_exp(input logic w);
        exp_t e;
        e.t = tk[0]; e.w = w; e.a = al_m;
        for (int k = 0; k < 3; k++) begin
            e.tp0[k] = tk[2][TAPB[k]] ^ tk[3][TAPB[k]];
            e.tp1[k] = tk[2][TAPB[k]] & ~tk[3][TAPB[k]];
        end
        sbq.push_back(e);
    endtask

    task automatic model_edge();
        logic w;
        w = 1'b0;
        if (rst) begin
            model_zero();
        end else begin
            old = tk[0];
            if (cmp_arm) begin
                armed_m = 1'b1; cmpv_m = cmp_val; al_m = 1'b0;
            end else if (armed_m && old == cmpv_m) begin
                armed_m = 1'b0; al_m = 1'b1;
            end else begin
                al_m = 1'b0;
            end
            if (clr) begin
                ideal = '0; h1 = '0; h2 = '0;
                for (int i = 0; i < 4; i++) tk[i] = '0;
            end else begin
                if (en) ideal = 8'(ideal + 8'd1);
                tk[3] = tk[2]; tk[2] = tk[1]; tk[1] = tk[0];
                tk[0] = h2; h2 = h1; h1 = ideal;
                w = (tk[0] == 8'd0) && (tk[1] == 8'd255);
            end
        end
        push_exp(w);
    endtask

    task automatic step(input logic e, input logic c, input logic a, input logic [7:0] v);
        en = e; clr = c; cmp_arm = a; cmp_val = v;
        @(posedge clk);
        model_edge();
        #2;
    endtask

    task automatic run_until(input logic [7:0] target, input logic e);
        int n;
        n = 0;
        while (tk[0] != target && n < 600) begin
            step(e, 1'b0, 1'b0, 8'd0);
            n++;
        end
        if (tk[0] != target) begin
            $display("FAIL run_until: ticks %0d never reached %0d", tk[0], target);
            miscompares++;
        end
    endtask

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or async_chk);
            #1;
            if (!done) begin
                if (sbq.size() == 0) begin
                    $display("FAIL underflow: DUT output with no expectation queued");
                    miscompares++;
                end else begin
                    e = sbq.pop_front();
                    vectors++;
                    if (ticks0 !== e.t || ticks1 !== e.t || taps0 !== e.tp0 || taps1 !== e.tp1 ||
                        wrap0 !== e.w || wrap1 !== e.w || alarm0 !== e.a || alarm1 !== e.a) begin
                        $display("FAIL vec %0d @%0t: got ticks=%0d/%0d taps0=%b taps1=%b wrap=%b/%b alarm=%b/%b, want ticks=%0d taps0=%b taps1=%b wrap=%b alarm=%b",
                                 vectors, $time, ticks0, ticks1, taps0, taps1, wrap0, wrap1,
                                 alarm0, alarm1, e.t, e.tp0, e.tp1, e.w, e.a);
                        miscompares++;
                    end
                end
            end
        end
    end

    // driver
    initial begin
        model_zero();
        rst = 1'b1; en = 1'b0; clr = 1'b0; cmp_arm = 1'b0; cmp_val = '0;
        repeat (2) step(1'b0, 1'b0, 1'b0, 8'd0);
        rst = 1'b0;

        // free count through 7->8 and 255->0, alarm armed at 5 for 20
        run_until(8'd5, 1'b1);
        step(1'b1, 1'b0, 1'b1, 8'd20);
        repeat (275) step(1'b1, 1'b0, 1'b0, 8'd0);

        // clear at 100 while counting
        run_until(8'd100, 1'b1);
        step(1'b1, 1'b1, 1'b0, 8'd0);
        repeat (6) step(1'b1, 1'b0, 1'b0, 8'd0);

        // en pattern 1,0,0,1 from a settled ticks=10
        run_until(8'd8, 1'b1);
        repeat (2) step(1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 1'b0, 8'd0);
        step(1'b1, 1'b0, 1'b0, 8'd0);
        repeat (3) step(1'b0, 1'b0, 1'b0, 8'd0);

        // alarm with ticks held at the compare value: one shot only
        step(1'b0, 1'b0, 1'b1, 8'd14);
        repeat (2) step(1'b1, 1'b0, 1'b0, 8'd0);
        repeat (6) step(1'b0, 1'b0, 1'b0, 8'd0);

        // re-arm on the matching cycle wins over the match
        step(1'b0, 1'b0, 1'b1, 8'd14);
        step(1'b0, 1'b0, 1'b1, 8'd200);
        repeat (4) step(1'b0, 1'b0, 1'b0, 8'd0);

        // armed for 90, then async reset at 77 drops it
        step(1'b0, 1'b0, 1'b1, 8'd90);
        run_until(8'd77, 1'b1);
        #1;
        rst = 1'b1;
        model_zero();
        push_exp(1'b0);
        ->async_chk;
        #2;
        repeat (2) step(1'b1, 1'b0, 1'b0, 8'd0);
        rst = 1'b0;
        repeat (100) step(1'b1, 1'b0, 1'b0, 8'd0);

        done = 1'b1;
        #3;
        if (sbq.size() != 0) begin
            $display("FAIL drain: %0d expectations left unchecked, want 0", sbq.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/timebase_v2.md
TIMEBASE_V2 -- requirements
Module: timebase_v2

Interface
REQ-001 SHALL have parameter WIDTH, default 27: total counter width; legal range 2..32.
REQ-002 SHALL have parameter LO_WIDTH, default 12: low-segment width; legal range 1..WIDTH-1.
REQ-003 SHALL have parameter NTAPS, default 6: tap count; legal range 2..WIDTH.
REQ-004 SHALL have parameter TAP_MODE, default 0: 0 = pulse on any tap-bit transition, 1 = pulse on rising transition only.
REQ-005 SHALL have port clk, input, 1: the single clock; all state is on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port en, input, 1: count enable, sampled each edge.
REQ-008 SHALL have port clr, input, 1: synchronous clear of the count path.
REQ-009 SHALL have port cmp_arm, input, 1: one-cycle strobe that latches cmp_val and arms the alarm.
REQ-010 SHALL have port cmp_val, input, WIDTH: alarm compare value.
REQ-011 SHALL have port ticks, output, WIDTH: registered monotonic timebase.
REQ-012 SHALL have port taps, output, NTAPS: registered single-cycle tap strobes.
REQ-013 SHALL have port wrap, output, 1: single-cycle wrap strobe.
REQ-014 SHALL have port alarm, output, 1: single-cycle compare-match strobe.

Function
REQ-015 Counter SHALL be split into lo (LO_WIDTH bits) and hi (WIDTH-LO_WIDTH bits), with no combinational carry from lo into hi.
REQ-016 lo SHALL increment by 1 on each edge with en=1, wrapping at all-ones to 0; carry_d SHALL register (en=1 AND lo=all-ones); hi SHALL add carry_d every edge.
REQ-017 lo SHALL be delayed one edge (lo_d), and ticks SHALL register {hi, lo_d}, so hi and lo are aligned.
REQ-018 Latency: an en=1 sample at edge n SHALL be reflected in ticks after edge n+2; en=0 SHALL hold ticks after the pipeline drains.
REQ-019 ticks SHALL be non-decreasing, step by at most 1 per cycle, never show a stale hi at a lo wrap, and wrap only from all-ones to 0.
REQ-020 Tap k SHALL monitor ticks bit (k*(WIDTH-1))/(NTAPS-1), computed at elaboration.
REQ-021 Per tap, prev SHALL register the monitored bit and edge SHALL register (bit XOR prev) for TAP_MODE 0, or (bit AND NOT prev) for TAP_MODE 1; taps SHALL register edge.
REQ-022 A tap strobe SHALL therefore appear 2 cycles after the ticks change that causes it, and SHALL be exactly 1 cycle wide per qualifying transition.
REQ-023 wrap SHALL be 1 for exactly the cycle in which ticks first reads 0 after reading all-ones, and SHALL be 0 otherwise.
REQ-024 cmp_arm=1 SHALL latch cmp_val into cmp_q and set armed; re-arming while armed SHALL overwrite cmp_q.
REQ-025 When armed=1 and ticks=cmp_q with no cmp_arm that edge, alarm SHALL be 1 the next cycle and armed SHALL clear (one-shot, even if ticks holds).
REQ-026 cmp_arm SHALL take precedence over a simultaneous match on the old cmp_q: no alarm, and the new value is armed.
REQ-027 clr=1 SHALL zero lo, lo_d, carry_d, hi, ticks, prev, edge, taps and wrap on that edge, overriding en, with no tap or wrap strobe caused by the clear; armed, cmp_q and alarm SHALL be unaffected.
REQ-028 After clr, counting SHALL resume from 0 under REQ-018 latency.

Reset
REQ-029 rst=1 SHALL immediately force all registers, including armed and cmp_q, to 0, with no clock required.
REQ-030 While rst=1, outputs SHALL hold ticks=0, taps=0, wrap=0, alarm=0.
REQ-031 After rst deasserts, the first en=1 edge SHALL begin counting, and no strobe SHALL occur before a qualifying event.

Verification (WIDTH=8, LO_WIDTH=3, NTAPS=3, taps on bits 0/3/7)
REQ-032 Reset, then en=1 continuously -> ticks 0,0,1,2,...; steps 7->8 and 255->0 with no glitch value; wrap=1 only at the 0 following 255.
REQ-033 en pattern 1,0,0,1 from ticks=10 -> ticks 11 held two cycles, then 12, delayed 2 cycles.
REQ-034 TAP_MODE 0 -> taps[0] every cycle while counting; TAP_MODE 1 -> taps[0] every other cycle and taps[1] once per 16 counts, each 2 cycles after the ticks bit change.
REQ-035 clr pulse at ticks=100 with en=1 -> ticks=0 next cycle, then 0,1,2 per REQ-018; no taps or wrap strobe from the clear.
REQ-036 cmp_arm with cmp_val=20 at ticks=5 -> single alarm the cycle after ticks=20, even with en=0 holding 20; cmp_arm on the matching cycle -> no alarm.
REQ-037 rst asserted mid-edge-free interval at ticks=77 -> ticks, taps, wrap, alarm=0 immediately; armed alarm lost.
